alu_fpga_seq: RTL and testbench
===============================

Name: alu_fpga_seq

Overview:
Board-level interactive ALU test harness, the successor to the switch-driven ALU FPGA wrapper. It debounces push-buttons and assembles wide operands A and B plus the ALU opcode from switches over several key presses. It drives an external alu instance's ports from registers, then latches the result and flags. Result and operands are shown on a parametrised bank of active-low seven-segment digits.

Parameters:
DATA_W, 32, ALU operand/result width
IN_W, 16, switch bits shifted in per SHIFT press (1..DATA_W)
ALUOP_W, 4, ALU opcode width
NDIGITS, 8, seven-segment digits driven
DEB_CYC, 50000, consecutive stable cycles before a key level is accepted (>=2)

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
key_n  in  4  raw push-buttons, active-low: [0] SHIFT, [1] NEXT, [2] NEG, [3] CLEAR
sw  in  IN_W  switch data
alu_porta  out  DATA_W  operand A register to ALU
alu_portb  out  DATA_W  operand B register to ALU
alu_op  out  ALUOP_W  opcode register to ALU
alu_out  in  DATA_W  ALU result (combinational from ports)
alu_zf, alu_nf, alu_of  in  1 each  ALU flags
hex  out  NDIGITS*7  digit i = hex[7i+6:7i], segments g..a, active-low
ledr  out  5  [1:0] state code, [2] zf, [3] nf, [4] of (latched)

Behaviour:
- One clock, CLK. nRST is asynchronous and active-low. Every flop clears on reset.
- Reset values: A=B=op=result=0; state ENT_A; latched flags 0; debounced key levels = released (1); debounce counters 0. Outputs under reset: alu_porta=alu_portb=alu_op=0, ledr=0, every digit within DATA_W shows '0' (7'b1000000).
- Key path, per key:
  - 2-flop synchroniser.
  - Counter runs while the synced level differs from the debounced level, and resets to 0 when they match.
  - Debounced level flips when the counter reaches DEB_CYC-1.
  - A one-cycle press pulse fires on a debounced 1->0 transition. Release generates no pulse. Holding a key gives exactly one pulse.
- Press latency from raw edge to pulse: 2 (sync) + DEB_CYC cycles.
- Simultaneous pulses in one cycle: priority CLEAR > NEXT > NEG > SHIFT. Lower-priority pulses are dropped.
- FSM states, with ledr[1:0] code: ENT_A=00, ENT_B=01, ENT_OP=10, SHOW=11.
- NEXT transitions: ENT_A->ENT_B->ENT_OP->SHOW->ENT_A. Operands and op are retained on SHOW->ENT_A.
- SHIFT:
  - In ENT_A / ENT_B: the current operand is shifted left by IN_W and sw fills the LSBs, truncated to DATA_W. If IN_W==DATA_W the operand is loaded directly.
  - In ENT_OP: op <= sw[ALUOP_W-1:0].
  - Ignored in SHOW.
- NEG: in ENT_A / ENT_B the current operand becomes its two's complement, modulo 2^DATA_W (0 stays 0, 0x80000000 stays 0x80000000). Ignored in ENT_OP and SHOW.
- CLEAR, from any state: A, B, op, result and flags go to 0, and the state goes to ENT_A, on the next edge.
- Entering SHOW: on the edge of the ENT_OP->SHOW transition, result <= alu_out and flags <= {alu_of, alu_nf, alu_zf}. Both are held until the next SHOW entry or CLEAR. ALU inputs are registered, so alu_out is stable at this point.
- Display source by state: A in ENT_A, B in ENT_B, zero-extended op in ENT_OP, result in SHOW.
- Digit i shows nibble [4i+3:4i]. Digits with 4i >= DATA_W are blank (7'b1111111). A partial top nibble is zero-extended.
- Hex encoding, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,27,21,06,0E (7-bit hex).
- Display and ledr are registered one cycle after the source value changes.
- Reset asserted mid-press or mid-debounce: all state lost. A key still held at release of reset produces no pulse until it is released and pressed again.

Test Plan:
1. Bench uses DEB_CYC=4. Reset, release; sample hex and ledr -> all 8 digits = 7'h40, ledr=0, alu_porta=0.
2. In ENT_A, sw=16'h1234 SHIFT, then sw=16'hABCD SHIFT -> alu_porta=32'h1234ABCD, hex = "1234ABCD" with digit 0 = 7'h21 ('D'), digit 7 = 7'h79 ('1').
3. A=5; NEXT; B=5 via SHIFT; NEXT; sw=SUB opcode SHIFT; NEXT with a bench ALU model -> state SHOW, ledr=5'b001_11 (zf set), all digits 7'h40.
4. A=1 then NEG -> alu_porta=32'hFFFFFFFF. A=32'h80000000 then NEG -> unchanged.
5. Bounce: toggle key_n[0] low/high every 2 cycles for 20 cycles, then hold low 10 cycles -> exactly one SHIFT applied. Holding for 100 more cycles -> no further shifts.
6. CLEAR and NEXT pulse in the same cycle while in ENT_B -> state ENT_A, A=B=op=0, flags 0. Assert nRST mid-debounce -> counters and state at reset values immediately (asynchronously).

Source files
------------

// File: rtl/alu_fpga_seq.sv
// Interactive ALU test harness for a board. Debounced push-buttons build the
// operands and opcode from switches, drive an external ALU, latch its result
// and flags, and show values on active-low seven-segment digits.

// Per-key front end: synchroniser, debouncer, press-pulse generator.
module alu_key_deb #(
    parameter int DEB_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);
    localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    logic [1:0]       wu_q;    // sync pipeline warm-up after reset
    logic             arm_q;   // key has been seen released since reset
    logic             deb_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    // Sync, debounce and emit one pulse per accepted press; a key held through
    // reset stays disarmed until it is observed released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            wu_q    <= 2'd0;
            arm_q   <= 1'b0;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_ni};
            press_q <= 1'b0;
            if (wu_q != 2'd2) wu_q <= wu_q + 2'd1;
            if (wu_q == 2'd2 && sync_q[1]) arm_q <= 1'b1;
            if (sync_q[1] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q   <= '0;
                deb_q   <= sync_q[1];
                press_q <= ~sync_q[1] & arm_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;
endmodule

module alu_fpga_seq #(
    parameter int DATA_W  = 32,
    parameter int IN_W    = 16,
    parameter int ALUOP_W = 4,
    parameter int NDIGITS = 8,
    parameter int DEB_CYC = 50000
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [3:0]           key_n,
    input  logic [IN_W-1:0]      sw,
    output logic [DATA_W-1:0]    alu_porta,
    output logic [DATA_W-1:0]    alu_portb,
    output logic [ALUOP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_zf,
    input  logic                 alu_nf,
    input  logic                 alu_of,
    output logic [NDIGITS*7-1:0] hex,
    output logic [4:0]           ledr
);
    typedef enum logic [1:0] {
        ENT_A  = 2'b00,
        ENT_B  = 2'b01,
        ENT_OP = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic [3:0] press;

    alu_key_deb #(.DEB_CYC(DEB_CYC)) u_deb [3:0] (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .key_ni (key_n),
        .press_o(press)
    );

    // Priority resolution: CLEAR > NEXT > NEG > SHIFT.
    logic do_clr, do_nxt, do_neg, do_shf;
    assign do_clr = press[3];
    assign do_nxt = press[1] & ~press[3];
    assign do_neg = press[2] & ~press[3] & ~press[1];
    assign do_shf = press[0] & ~press[3] & ~press[1] & ~press[2];

    state_t              state_q;
    logic [DATA_W-1:0]   a_q, b_q, res_q;
    logic [ALUOP_W-1:0]  op_q;
    logic [2:0]          flg_q;   // {of, nf, zf}

    // Shift IN_W switch bits into the low end, keeping the low DATA_W bits.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic [IN_W-1:0]   s);
        logic [DATA_W+IN_W-1:0] t;
        t = {v, s};
        return t[DATA_W-1:0];
    endfunction

    // Entry FSM: operand/opcode editing and result capture on SHOW entry.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else if (do_clr) begin
            state_q <= ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else if (do_nxt) begin
            case (state_q)
                ENT_A:   state_q <= ENT_B;
                ENT_B:   state_q <= ENT_OP;
                ENT_OP: begin
                    state_q <= SHOW;
                    res_q   <= alu_out;
                    flg_q   <= {alu_of, alu_nf, alu_zf};
                end
                default: state_q <= ENT_A;
            endcase
        end else if (do_neg) begin
            if (state_q == ENT_A) a_q <= '0 - a_q;
            if (state_q == ENT_B) b_q <= '0 - b_q;
        end else if (do_shf) begin
            case (state_q)
                ENT_A:   a_q  <= shift_in(a_q, sw);
                ENT_B:   b_q  <= shift_in(b_q, sw);
                ENT_OP:  op_q <= sw[ALUOP_W-1:0];
                default: ;
            endcase
        end
    end

    assign alu_porta = a_q;
    assign alu_portb = b_q;
    assign alu_op    = op_q;

    logic [DATA_W-1:0] disp_src;

    // Display source follows the current state.
    always_comb begin
        disp_src = res_q;
        case (state_q)
            ENT_A:   disp_src = a_q;
            ENT_B:   disp_src = b_q;
            ENT_OP:  disp_src = DATA_W'(op_q);
            default: disp_src = res_q;
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h27;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
        if (4 * g >= DATA_W) begin : g_blank
            assign hex[7*g +: 7] = 7'h7F;
        end else begin : g_nib
            logic [3:0] nib;
            logic [6:0] seg_q;
            assign nib = 4'(disp_src >> (4 * g));
            // Registered digit driver.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) seg_q <= 7'h40;
                else       seg_q <= seg7(nib);
            end
            assign hex[7*g +: 7] = seg_q;
        end
    end

    logic [4:0] ledr_q;

    // Registered status LEDs: latched flags over the state code.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ledr_q <= '0;
        else       ledr_q <= {flg_q, state_q};
    end

    assign ledr = ledr_q;
endmodule

// File: tb/tb_alu_fpga_seq.sv
// Directed + randomized bench for alu_fpga_seq with a bench-side ALU and a
// behavioural model of the entry harness.
module tb_alu_fpga_seq;
    localparam int DEB = 4;
    localparam int HOLD = DEB + 8;

    logic        CLK = 0;
    logic        nRST = 0;
    logic [3:0]  key_n = 4'hF;
    logic [15:0] sw = '0;
    logic [31:0] alu_porta, alu_portb, alu_out;
    logic [3:0]  alu_op;
    logic        alu_zf, alu_nf, alu_of;
    logic [55:0] hex;
    logic [4:0]  ledr;

    int n_chk = 0;
    int n_fail = 0;

    // Model state
    logic [31:0] mA, mB, mRes;
    logic [3:0]  mOp;
    int          mSt;
    logic [2:0]  mFlg;

    logic [6:0] SEG [16] = '{7'h40,7'h79,7'h24,7'h30,7'h19,7'h12,7'h02,7'h78,
                             7'h00,7'h10,7'h08,7'h03,7'h27,7'h21,7'h06,7'h0E};

    alu_fpga_seq #(.DEB_CYC(DEB)) dut (
        .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
        .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zf(alu_zf), .alu_nf(alu_nf), .alu_of(alu_of),
        .hex(hex), .ledr(ledr)
    );

    always #5 CLK = ~CLK;

    // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A.
    // Returns {of, nf, zf, result}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, b, input logic [3:0] op);
        logic [31:0] r;
        logic        o;
        o = 1'b0;
        case (op)
            4'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {o, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_of, alu_nf, alu_zf, alu_out} = alu_f(alu_porta, alu_portb, alu_op);

    function automatic logic [55:0] exp_hex(input logic [31:0] v);
        logic [55:0] h;
        for (int i = 0; i < 8; i++) h[7*i +: 7] = SEG[(v >> (4*i)) & 32'hF];
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mA = '0; mB = '0; mOp = '0; mRes = '0; mSt = 0; mFlg = '0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] src;
        case (mSt)
            0: src = mA;
            1: src = mB;
            2: src = {28'd0, mOp};
            default: src = mRes;
        endcase
        chk({tag, ".porta"}, 64'(alu_porta), 64'(mA));
        chk({tag, ".portb"}, 64'(alu_portb), 64'(mB));
        chk({tag, ".op"},    64'(alu_op),    64'(mOp));
        chk({tag, ".ledr"},  64'(ledr),      64'({mFlg, 2'(mSt)}));
        chk({tag, ".hex"},   64'(hex),       64'(exp_hex(src)));
    endtask

    // Press and release the keys in mask (bit set = pressed), update model.
    task automatic press(input logic [3:0] mask, input string tag);
        logic [34:0] r;
        key_n = ~mask;
        repeat (HOLD) @(posedge CLK);
        key_n = 4'hF;
        repeat (HOLD) @(posedge CLK);
        if (mask[3]) begin
            model_reset();
        end else if (mask[1]) begin
            if (mSt == 2) begin
                r = alu_f(mA, mB, mOp);
                mRes = r[31:0];
                mFlg = r[34:32];
            end
            mSt = (mSt + 1) % 4;
        end else if (mask[2]) begin
            if (mSt == 0) mA = -mA;
            else if (mSt == 1) mB = -mB;
        end else if (mask[0]) begin
            if (mSt == 0) mA = (mA << 16) | 32'(sw);
            else if (mSt == 1) mB = (mB << 16) | 32'(sw);
            else if (mSt == 2) mOp = sw[3:0];
        end
        @(negedge CLK);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // 1: reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst.hex", 64'(hex), {8'd0, {8{7'h40}}});
        chk("rst.ledr", 64'(ledr), 64'd0);
        nRST = 1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check_all("post_rst");

        // 2: two shifts build A
        sw = 16'h1234; press(4'b0001, "shA1");
        sw = 16'hABCD; press(4'b0001, "shA2");
        chk("t2.porta", 64'(alu_porta), 64'h1234ABCD);
        chk("t2.dig0", 64'(hex[6:0]), 64'h21);
        chk("t2.dig7", 64'(hex[55:49]), 64'h79);

        // 3: 5 - 5 = 0 sets zf
        press(4'b1000, "clr3");
        sw = 16'd5; press(4'b0001, "a5");
        press(4'b0010, "nxtB");
        sw = 16'd5; press(4'b0001, "b5");
        press(4'b0010, "nxtOp");
        sw = 16'd1; press(4'b0001, "opSub");
        press(4'b0010, "show");
        chk("t3.ledr", 64'(ledr), 64'b00111);
        chk("t3.hex", 64'(hex), {8'd0, {8{7'h40}}});
        press(4'b0010, "wrapA");

        // 4: negation boundaries
        press(4'b1000, "clr4");
        sw = 16'd1; press(4'b0001, "a1");
        press(4'b0100, "neg1");
        chk("t4.neg1", 64'(alu_porta), 64'hFFFFFFFF);
        sw = 16'h8000; press(4'b0001, "a8k");
        sw = 16'h0000; press(4'b0001, "a80M");
        press(4'b0100, "negMin");
        chk("t4.negmin", 64'(alu_porta), 64'h80000000);

        // 5: bounce then hold gives exactly one SHIFT
        press(4'b1000, "clr5");
        sw = 16'd3;
        for (int i = 0; i < 10; i++) begin
            key_n[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(posedge CLK);
        end
        key_n[0] = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        chk("t5.one", 64'(alu_porta), 64'd3);
        repeat (100) @(posedge CLK);
        @(negedge CLK);
        chk("t5.hold", 64'(alu_porta), 64'd3);
        key_n = 4'hF;
        repeat (HOLD) @(posedge CLK);
        mA = 32'd3;
        @(negedge CLK);
        check_all("t5.rel");

        // 6: CLEAR beats NEXT in ENT_B
        sw = 16'h00F0;
        press(4'b0010, "nxt6");
        press(4'b0001, "b6");
        press(4'b1010, "clrnxt");

        // Randomized sessions
        for (int it = 0; it < 6; it++) begin
            press(4'b1000, "rclr");
            sw = 16'($urandom); press(4'b0001, "rA1");
            sw = 16'($urandom); press(4'b0001, "rA2");
            if ($urandom_range(1, 0) == 1) press(4'b0100, "rnegA");
            press(4'b0010, "rnB");
            sw = 16'($urandom); press(4'b0001, "rB1");
            sw = 16'($urandom); press(4'b0001, "rB2");
            if ($urandom_range(1, 0) == 1) press(4'b0100, "rnegB");
            press(4'b0010, "rnOp");
            sw = 16'($urandom_range(5, 0)); press(4'b0001, "rOp");
            press(4'b0010, "rShow");
            press(4'b0001, "rShIgn");
            press(4'b0100, "rNegIgn");
        end

        // Async reset mid-debounce, key held through reset
        press(4'b0010, "toA");
        sw = 16'h0042; press(4'b0001, "preR");
        key_n[0] = 1'b0;
        repeat (3) @(posedge CLK);
        #2 nRST = 0;
        #1;
        model_reset();
        chk("ar.porta", 64'(alu_porta), 64'd0);
        chk("ar.ledr", 64'(ledr), 64'd0);
        chk("ar.hex", 64'(hex), {8'd0, {8{7'h40}}});
        repeat (2) @(posedge CLK);
        #2 nRST = 1;
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        chk("ar.held", 64'(alu_porta), 64'd0);
        key_n = 4'hF;
        repeat (HOLD) @(posedge CLK);
        sw = 16'd7; press(4'b0001, "ar.again");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
